// File: rtl/tri_bbox_pkg.sv
// Shared types and default configuration for the triangle bounding-box unit.
package tri_bbox_pkg;

    // Default configuration: 18-bit coordinates with 6 fractional bits, 640x480 screen.
    localparam int unsigned WIDTH_DEF  = 18;
    localparam int unsigned FRAC_DEF   = 6;
    localparam int unsigned PIX_W_DEF  = 10;
    localparam int unsigned XCLAMP     = 640 - 1;
    localparam int unsigned YCLAMP     = 480 - 1;
    localparam int unsigned ROUND_HALF = 1 << (FRAC_DEF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINAL,
        DONE
    } state_e;

endpackage

// File: rtl/fxp_round_clamp.sv
// Round a signed fixed-point value half-up to an integer and clamp it to 0..LIMIT.
// o_below / o_above report the rounded value before clamping.
module fxp_round_clamp
    import tri_bbox_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF,
    parameter int unsigned LIMIT = XCLAMP
) (
    input  logic signed [WIDTH-1:0] i_val,
    output logic        [PIX_W-1:0] o_pix,
    output logic                    o_below,
    output logic                    o_above
);

    localparam int unsigned HALF  = (FRAC == FRAC_DEF) ? ROUND_HALF : (1 << (FRAC - 1));
    localparam int          LIM_S = int'(LIMIT);

    logic signed [WIDTH:0] w_sum;
    logic signed [WIDTH:0] w_rnd;
    logic signed [31:0]    w_ext;

    // One extra bit so adding the half LSB cannot overflow.
    assign w_sum   = $signed({i_val[WIDTH-1], i_val}) + $signed((WIDTH+1)'(HALF));
    assign w_rnd   = w_sum >>> FRAC;
    assign w_ext   = 32'(w_rnd);
    assign o_below = (w_ext < 0);
    assign o_above = (w_ext > LIM_S);
    assign o_pix   = o_below ? '0 : (o_above ? PIX_W'(LIMIT) : w_rnd[PIX_W-1:0]);

endmodule

// File: rtl/tri_bbox_unit.sv
// Sequential triangle bounding-box unit: accept one triangle per handshake, scan the
// three vertices for min/max, then round to pixels and clamp to the screen.
// Optional build macro BBOX_CULL_EN: offscreen triangles are dropped and counted.
module tri_bbox_unit
    import tri_bbox_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned FRAC     = FRAC_DEF,
    parameter int unsigned PIX_W    = PIX_W_DEF,
    parameter int unsigned SCREEN_W = XCLAMP + 1,
    parameter int unsigned SCREEN_H = YCLAMP + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] v0x,
    input  logic signed [WIDTH-1:0] v1x,
    input  logic signed [WIDTH-1:0] v2x,
    input  logic signed [WIDTH-1:0] v0y,
    input  logic signed [WIDTH-1:0] v1y,
    input  logic signed [WIDTH-1:0] v2y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic        [PIX_W-1:0] xmin,
    output logic        [PIX_W-1:0] xmax,
    output logic        [PIX_W-1:0] ymin,
    output logic        [PIX_W-1:0] ymax,
    output logic                    offscreen,
    output logic [15:0]             cull_cnt
);

    state_e                  r_state;
    logic [1:0]              r_idx;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic signed [WIDTH-1:0] r_v0x, r_v1x, r_v2x, r_v0y, r_v1y, r_v2y;
    logic signed [WIDTH-1:0] r_run_xmin, r_run_xmax, r_run_ymin, r_run_ymax;
    logic [PIX_W-1:0]        r_xmin, r_xmax, r_ymin, r_ymax;
    logic                    r_offscreen;

    logic signed [WIDTH-1:0] w_cx, w_cy;
    logic [PIX_W-1:0]        w_xmin_pix, w_xmax_pix, w_ymin_pix, w_ymax_pix;
    logic                    w_xmin_below, w_xmin_above, w_xmax_below, w_xmax_above;
    logic                    w_ymin_below, w_ymin_above, w_ymax_below, w_ymax_above;
    logic                    w_offscreen;
    logic                    w_unused_flags;

    // Select the vertex being scanned this cycle.
    always_comb begin
        w_cx = r_v0x;
        w_cy = r_v0y;
        case (r_idx)
            2'd1: begin
                w_cx = r_v1x;
                w_cy = r_v1y;
            end
            2'd2: begin
                w_cx = r_v2x;
                w_cy = r_v2y;
            end
            default: begin
                w_cx = r_v0x;
                w_cy = r_v0y;
            end
        endcase
    end

    fxp_round_clamp #(.WIDTH(WIDTH), .FRAC(FRAC), .PIX_W(PIX_W), .LIMIT(SCREEN_W - 1)) u_xmin (
        .i_val(r_run_xmin), .o_pix(w_xmin_pix), .o_below(w_xmin_below), .o_above(w_xmin_above)
    );
    fxp_round_clamp #(.WIDTH(WIDTH), .FRAC(FRAC), .PIX_W(PIX_W), .LIMIT(SCREEN_W - 1)) u_xmax (
        .i_val(r_run_xmax), .o_pix(w_xmax_pix), .o_below(w_xmax_below), .o_above(w_xmax_above)
    );
    fxp_round_clamp #(.WIDTH(WIDTH), .FRAC(FRAC), .PIX_W(PIX_W), .LIMIT(SCREEN_H - 1)) u_ymin (
        .i_val(r_run_ymin), .o_pix(w_ymin_pix), .o_below(w_ymin_below), .o_above(w_ymin_above)
    );
    fxp_round_clamp #(.WIDTH(WIDTH), .FRAC(FRAC), .PIX_W(PIX_W), .LIMIT(SCREEN_H - 1)) u_ymax (
        .i_val(r_run_ymax), .o_pix(w_ymax_pix), .o_below(w_ymax_below), .o_above(w_ymax_above)
    );

    // Offscreen only when the whole box misses the screen on some axis.
    assign w_offscreen    = w_xmax_below | w_xmin_above | w_ymax_below | w_ymin_above;
    assign w_unused_flags = w_xmin_below | w_xmax_above | w_ymin_below | w_ymax_above;

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign xmin      = r_xmin;
    assign xmax      = r_xmax;
    assign ymin      = r_ymin;
    assign ymax      = r_ymax;
    assign offscreen = r_offscreen;

`ifdef BBOX_CULL_EN
    logic [15:0] r_cull_cnt;
    assign cull_cnt = r_cull_cnt;
`else
    assign cull_cnt = '0;
`endif

    // Control FSM with vertex capture, min/max scan and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_offscreen <= 1'b0;
`ifdef BBOX_CULL_EN
            r_cull_cnt  <= '0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_v0x      <= v0x;
                        r_v1x      <= v1x;
                        r_v2x      <= v2x;
                        r_v0y      <= v0y;
                        r_v1y      <= v1y;
                        r_v2y      <= v2y;
                        r_idx      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (r_idx == 2'd0) begin
                        r_run_xmin <= w_cx;
                        r_run_xmax <= w_cx;
                        r_run_ymin <= w_cy;
                        r_run_ymax <= w_cy;
                    end else begin
                        if (w_cx < r_run_xmin) r_run_xmin <= w_cx;
                        if (w_cx > r_run_xmax) r_run_xmax <= w_cx;
                        if (w_cy < r_run_ymin) r_run_ymin <= w_cy;
                        if (w_cy > r_run_ymax) r_run_ymax <= w_cy;
                    end
                    if (r_idx == 2'd2) r_state <= FINAL;
                    else               r_idx   <= r_idx + 2'd1;
                end
                FINAL: begin
                    r_xmin      <= w_xmin_pix;
                    r_xmax      <= w_xmax_pix;
                    r_ymin      <= w_ymin_pix;
                    r_ymax      <= w_ymax_pix;
                    r_offscreen <= w_offscreen;
`ifdef BBOX_CULL_EN
                    if (w_offscreen) begin
                        r_cull_cnt <= r_cull_cnt + 16'd1;
                        r_in_ready <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
`else
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_bbox_unit.sv
// Scoreboard bench for tri_bbox_unit (WIDTH=18, FRAC=6, 640x480).
module tb_tri_bbox_unit;

    typedef struct packed {
        logic [9:0] xmin;
        logic [9:0] xmax;
        logic [9:0] ymin;
        logic [9:0] ymax;
        logic       off;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [17:0] v0x, v1x, v2x, v0y, v1y, v2y;
    logic [9:0]  xmin, xmax, ymin, ymax;
    logic        offscreen;
    logic [15:0] cull_cnt;

    res_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cull = 0;

    always #5 clk = ~clk;

    tri_bbox_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .v0x(v0x), .v1x(v1x), .v2x(v2x), .v0y(v0y), .v1y(v1y), .v2y(v2y),
        .out_valid(out_valid), .out_ready(out_ready),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
        .offscreen(offscreen), .cull_cnt(cull_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compare each delivered box against the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("bbox", 64'({xmin, xmax, ymin, ymax, offscreen}), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Present a triangle and hold it until accepted; returns #1 after the accepting edge.
    task automatic apply(input logic [17:0] x0, x1, x2, y0, y1, y2,
                         input res_t e, input bit push);
        int k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("in_ready_before_send", 64'(in_ready), 64'd1);
        v0x = x0; v1x = x1; v2x = x2;
        v0y = y0; v1y = y1; v2y = y2;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the result (out_ready high), checking latency and the handshake.
    task automatic wait_result();
        int k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (out_valid) break;
        end
        // Accepting edge plus four more edges: valid after the 5th edge counting the accept.
        check("latency", 64'(k), 64'd4);
        @(posedge clk);
        #1;
        check("handshake_drop", 64'({out_valid, in_ready}), 64'b01);
    endtask

    task automatic run_tri(input logic [17:0] x0, x1, x2, y0, y1, y2, input res_t e);
        bit seen = 1'b0;
`ifdef BBOX_CULL_EN
        if (e.off) begin
            apply(x0, x1, x2, y0, y1, y2, e, 1'b0);
            exp_cull++;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                seen = seen | out_valid;
            end
            check("cull_no_valid", 64'(seen), 64'd0);
            check("cull_ready", 64'(in_ready), 64'd1);
            check("cull_cnt", 64'(cull_cnt), 64'(exp_cull));
            return;
        end
`endif
        apply(x0, x1, x2, y0, y1, y2, e, 1'b1);
        wait_result();
        check("cull_cnt_idle", 64'(cull_cnt | 16'(seen)), 64'(exp_cull));
    endtask

    localparam res_t R_BASIC  = '{xmin: 10'd2, xmax: 10'd11, ymin: 10'd2, ymax: 10'd7, off: 1'b0};
    localparam res_t R_CLAMP  = '{xmin: 10'd0, xmax: 10'd639, ymin: 10'd50, ymax: 10'd50, off: 1'b0};
    localparam res_t R_OFF_X  = '{xmin: 10'd0, xmax: 10'd0, ymin: 10'd50, ymax: 10'd50, off: 1'b1};
    localparam res_t R_OFF_Y  = '{xmin: 10'd5, xmax: 10'd5, ymin: 10'd479, ymax: 10'd479, off: 1'b1};
    localparam res_t R_HALF   = '{xmin: 10'd1, xmax: 10'd1, ymin: 10'd1, ymax: 10'd1, off: 1'b0};
    localparam res_t R_ZERO   = '{xmin: 10'd0, xmax: 10'd0, ymin: 10'd0, ymax: 10'd0, off: 1'b0};

    initial begin
        int k;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        v0x = '0; v1x = '0; v2x = '0; v0y = '0; v1y = '0; v2y = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 64'({in_ready, out_valid, xmin, xmax, ymin, ymax, offscreen, cull_cnt}),
              64'({1'b1, 1'b0, 40'd0, 1'b0, 16'd0}));
        rst = 1'b0;

        // Basic and clamp cases.
        run_tri(18'h00090, 18'h002A0, 18'h00140, 18'h000C0, 18'h00070, 18'h001DF, R_BASIC);
        run_tri(18'h3FF40, 18'h0AF00, 18'h01900, 18'h00C80, 18'h00C80, 18'h00C80, R_CLAMP);

        // Offscreen left of the screen and below the bottom edge.
        run_tri(18'h3F000, 18'h3F000, 18'h3F000, 18'h00C80, 18'h00C80, 18'h00C80, R_OFF_X);
        run_tri(18'h00140, 18'h00140, 18'h00140, 18'h07800, 18'h07800, 18'h07800, R_OFF_Y);

        // Rounding ties on degenerate triangles: 0.5 -> 1, -0.5 -> 0, 31/64 -> 0.
        run_tri(18'h00020, 18'h00020, 18'h00020, 18'h00020, 18'h00020, 18'h00020, R_HALF);
        run_tri(18'h3FFE0, 18'h3FFE0, 18'h3FFE0, 18'h3FFE0, 18'h3FFE0, 18'h3FFE0, R_ZERO);
        run_tri(18'h0001F, 18'h0001F, 18'h0001F, 18'h0001F, 18'h0001F, 18'h0001F, R_ZERO);

        // Backpressure: hold in DONE for 10 cycles, then release and accept immediately.
        out_ready = 1'b0;
        apply(18'h00090, 18'h002A0, 18'h00140, 18'h000C0, 18'h00070, 18'h001DF, R_BASIC, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 64'({out_valid, in_ready, xmin, xmax, ymin, ymax, offscreen}),
                  64'({1'b1, 1'b0, R_BASIC}));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 64'({out_valid, in_ready}), 64'b01);
        apply(18'h3FF40, 18'h0AF00, 18'h01900, 18'h00C80, 18'h00C80, 18'h00C80, R_CLAMP, 1'b1);
        check("accept_after_bp", 64'(in_ready), 64'd0);
        wait_result();

        // Reset while scanning vertex 1 drops the triangle.
        apply(18'h00090, 18'h002A0, 18'h00140, 18'h000C0, 18'h00070, 18'h001DF, R_BASIC, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cull = 0;
        check("reset_mid_scan", 64'({in_ready, out_valid, xmin, xmax, ymin, ymax, offscreen, cull_cnt}),
              64'({1'b1, 1'b0, 40'd0, 1'b0, 16'd0}));
        run_tri(18'h00090, 18'h002A0, 18'h00140, 18'h000C0, 18'h00070, 18'h001DF, R_BASIC);

        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
